decode_stage: RTL and testbench



---
 rtl/decode_stage.sv | 165 ++++++++++++++++
 tb/tb_decode_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Registered RV32I ALU decode stage with valid/ready handshake and a one-entry skid buffer.
// Optional `DECODE_STATS_EN adds saturating transfer and illegal-instruction counters.
module decode_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  regwrite_control,
  output logic                  alu_src_imm,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]       imm,
  output logic                  illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]           stat_decoded,
  output logic [31:0]           stat_illegal
`endif
);

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] alu;
    logic                  regwrite;
    logic                  src_imm;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       imm;
    logic                  illegal;
  } bundle_t;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  function automatic bundle_t decode(input logic [31:0] instr);
    bundle_t            b;
    logic [6:0]         op;
    logic [6:0]         f7;
    logic [2:0]         f3;
    logic               is_r;
    logic               is_i;
    logic               bad_f7;
    logic [3:0]         code;
    logic signed [11:0] imm12;
    op     = instr[6:0];
    f3     = instr[14:12];
    f7     = instr[31:25];
    is_r   = (op == OP_R);
    is_i   = (op == OP_I);
    imm12  = instr[31:20];
    bad_f7 = 1'b0;
    code   = 4'b0000;
    case (f3)
      3'd0: begin
        code   = (is_r && f7 == 7'h20) ? 4'b0100 : 4'b0010;
        bad_f7 = is_r && (f7 != 7'h00) && (f7 != 7'h20);
      end
      3'd1: begin
        code   = 4'b0011;
        bad_f7 = is_i && (f7 != 7'h00);
      end
      3'd2: code = 4'b1000;
      3'd3: code = 4'b1001;
      3'd4: code = 4'b0111;
      3'd5: begin
        code   = (f7 == 7'h20) ? 4'b1010 : 4'b0101;
        bad_f7 = (f7 != 7'h00) && (f7 != 7'h20);
      end
      3'd6: code = 4'b0001;
      default: code = 4'b0000;
    endcase
    b     = '0;
    b.rd  = REG_ADDR_W'(instr[11:7]);
    b.rs1 = REG_ADDR_W'(instr[19:15]);
    b.rs2 = REG_ADDR_W'(instr[24:20]);
    if (!(is_r || is_i) || bad_f7) begin
      b.illegal = 1'b1;
    end else begin
      b.alu      = ALU_CTRL_W'(code);
      b.regwrite = 1'b1;
      if (is_i) begin
        b.src_imm = 1'b1;
        b.rs2     = '0;
        // Shift immediates carry only the shift amount, never a sign.
        if (f3 == 3'd1 || f3 == 3'd5) b.imm = XLEN'(instr[24:20]);
        else                          b.imm = XLEN'(imm12);
      end
    end
    return b;
  endfunction

  bundle_t dec_p0;
  bundle_t out_p1;
  bundle_t skid_p1;
  logic    skid_full;
  logic    accept;
  logic    drain;

  // Stage 0: combinational decode of the incoming word
  assign dec_p0   = decode(in_instr);
  assign in_ready = !skid_full;
  assign accept   = in_valid && !skid_full;
  assign drain    = out_valid && out_ready;

  // Stage 1: output register plus skid entry; skid always holds the younger bundle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_p1    <= '0;
      skid_full <= 1'b0;
    end else if (skid_full) begin
      if (out_ready) begin
        out_p1    <= skid_p1;
        skid_full <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid || out_ready) begin
        out_p1    <= dec_p0;
        out_valid <= 1'b1;
      end else begin
        skid_full <= 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && out_valid && !out_ready) skid_p1 <= dec_p0;
  end

  assign alu_control      = out_p1.alu;
  assign regwrite_control = out_p1.regwrite;
  assign alu_src_imm      = out_p1.src_imm;
  assign rd               = out_p1.rd;
  assign rs1              = out_p1.rs1;
  assign rs2              = out_p1.rs2;
  assign imm              = out_p1.imm;
  assign illegal          = out_p1.illegal;

`ifdef DECODE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_decoded <= '0;
      stat_illegal <= '0;
    end else if (drain) begin
      if (stat_decoded != 32'hFFFF_FFFF) stat_decoded <= stat_decoded + 32'd1;
      if (out_p1.illegal && stat_illegal != 32'hFFFF_FFFF) stat_illegal <= stat_illegal + 32'd1;
    end
  end
`else
  logic unused_drain;
  assign unused_drain = drain;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode tables, illegal handling, skid backpressure, async reset.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_control;
  logic        regwrite_control;
  logic        alu_src_imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        illegal;
`ifdef DECODE_STATS_EN
  logic [31:0] stat_decoded;
  logic [31:0] stat_illegal;
`endif

  int checks = 0;
  int failures = 0;

  logic [53:0] got;
  assign got = {alu_control, regwrite_control, alu_src_imm, rd, rs1, rs2, imm, illegal};

  decode_stage dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .alu_control      (alu_control),
    .regwrite_control (regwrite_control),
    .alu_src_imm      (alu_src_imm),
    .rd               (rd),
    .rs1              (rs1),
    .rs2              (rs2),
    .imm              (imm),
    .illegal          (illegal)
`ifdef DECODE_STATS_EN
    ,
    .stat_decoded     (stat_decoded),
    .stat_illegal     (stat_illegal)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] w);
    in_instr = w;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (got !== 54'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", got); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_rtype();
    logic [31:0] w [4];
    logic [53:0] e [4];
    w[0] = 32'h002081B3; e[0] = {4'h2, 1'b1, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0};
    w[1] = 32'h40208233; e[1] = {4'h4, 1'b1, 1'b0, 5'd4, 5'd1, 5'd2, 32'h0, 1'b0};
    w[2] = 32'h4020D2B3; e[2] = {4'hA, 1'b1, 1'b0, 5'd5, 5'd1, 5'd2, 32'h0, 1'b0};
    w[3] = 32'h009463B3; e[3] = {4'h1, 1'b1, 1'b0, 5'd7, 5'd8, 5'd9, 32'h0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(w[i]);
      checks++;
      if ({out_valid, got} !== {1'b1, e[i]}) begin
        failures++;
        $display("FAIL rtype_%0d got=%b_%h exp=1_%h", i, out_valid, got, e[i]);
      end
    end
  endtask

  task automatic test_itype();
    logic [31:0] w [3];
    logic [53:0] e [3];
    w[0] = 32'hFFF08093; e[0] = {4'h2, 1'b1, 1'b1, 5'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b0};
    w[1] = 32'h4030D293; e[1] = {4'hA, 1'b1, 1'b1, 5'd5, 5'd1, 5'd0, 32'd3, 1'b0};
    w[2] = 32'hFF017313; e[2] = {4'h0, 1'b1, 1'b1, 5'd6, 5'd2, 5'd0, 32'hFFFFFFF0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(w[i]);
      checks++;
      if ({out_valid, got} !== {1'b1, e[i]}) begin
        failures++;
        $display("FAIL itype_%0d got=%b_%h exp=1_%h", i, out_valid, got, e[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w [3];
    logic [53:0] e [3];
    w[0] = 32'h0000007F; e[0] = {4'h0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1};
    w[1] = 32'h7E2081B3; e[1] = {4'h0, 1'b0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1};
    w[2] = 32'h40109093; e[2] = {4'h0, 1'b0, 1'b0, 5'd1, 5'd1, 5'd1, 32'h0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(w[i]);
      checks++;
      if ({out_valid, got} !== {1'b1, e[i]}) begin
        failures++;
        $display("FAIL illegal_%0d got=%b_%h exp=1_%h", i, out_valid, got, e[i]);
      end
    end
    @(posedge clk);
    #1;
`ifdef DECODE_STATS_EN
    checks++;
    if (stat_illegal !== 32'd3) begin failures++; $display("FAIL stat_illegal got=%0d exp=3", stat_illegal); end
    checks++;
    if (stat_decoded !== 32'd10) begin failures++; $display("FAIL stat_decoded got=%0d exp=10", stat_decoded); end
`endif
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL illegal_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [4];
    int  pi;
    int  ci;
    logic acc;
    logic drn;
    pi = 0;
    ci = 0;
    for (int i = 0; i < 4; i++) w[i] = (32'(10 + i) << 7) | 32'h33;
    out_ready = 1'b0;
    in_instr  = w[0];
    in_valid  = 1'b1;
    for (int cyc = 0; cyc < 40 && ci < 4; cyc++) begin
      out_ready = (cyc >= 4);
      @(negedge clk);
      if (cyc == 2) begin
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_ready got=%b exp=0", in_ready); end
        checks++;
        if ({out_valid, rd} !== {1'b1, 5'd10}) begin
          failures++;
          $display("FAIL b2b_hold got=%b_%0d exp=1_10", out_valid, rd);
        end
      end
      acc = in_valid && in_ready;
      drn = out_valid && out_ready;
      if (drn) begin
        checks++;
        if (rd !== 5'(10 + ci)) begin failures++; $display("FAIL b2b_order_%0d got=%0d exp=%0d", ci, rd, 10 + ci); end
        ci++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        pi++;
        if (pi < 4) in_instr = w[pi];
        else        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ci !== 4 || pi !== 4) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=4/4", ci, pi); end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(32'h002081B3);
    drive(32'h40208233);
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_full got=%b exp=0", in_ready); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_async_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_%0d got=%b exp=0", i, out_valid); end
    end
  endtask

  initial begin
    clk       = 1'b0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_illegal();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
